// File: rtl/abs_diff_approx_pipe.sv
// Two-stage elastic pipeline computing exact and LSB-truncated |a-b|,
// the truncation error, a threshold flag, and running error statistics.
module abs_diff_approx_pipe #(
   parameter int WIDTH    = 4,
   parameter int DROP_MAX = 3,
   parameter int ET       = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_drop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_exact,
   output logic [WIDTH-1:0] out_approx,
   output logic [WIDTH-1:0] out_err,
   output logic             out_viol,
   input  logic             clear_stats,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [WIDTH-1:0] max_err
);

   localparam int STAGES = 2;

   typedef struct packed {
      logic [WIDTH-1:0] exact;
      logic [2:0]       drop;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] exact;
      logic [WIDTH-1:0] approx;
      logic [WIDTH-1:0] err;
      logic             viol;
   } s2_t;

   logic [STAGES:1] vld_pipe;
   s1_t             s1_q, s1_d;
   s2_t             s2_q, s2_d;
   logic [WIDTH-1:0] drop_mask;
   logic            adv, out_fire;

   // Stage 2 drains or is empty; stage 1 moves with it. Reset holds ready low.
   assign adv      = ~vld_pipe[2] | out_ready;
   assign out_fire = vld_pipe[2] & out_ready;
   assign in_ready = rst_n & (~vld_pipe[1] | adv);

   // Stage 1 payload: absolute difference and clamped drop count.
   always_comb begin
      s1_d.exact = (in_a >= in_b) ? (in_a - in_b) : (in_b - in_a);
      s1_d.drop  = (int'(in_drop) > DROP_MAX) ? 3'(DROP_MAX) : in_drop;
   end

   // Stage 2 payload: split exact result into kept high bits and dropped low bits.
   always_comb begin
      drop_mask   = ~({WIDTH{1'b1}} << s1_q.drop);
      s2_d.exact  = s1_q.exact;
      s2_d.approx = s1_q.exact & ~drop_mask;
      s2_d.err    = s1_q.exact & drop_mask;
      s2_d.viol   = 32'(s2_d.err) > ET;
   end

   // Pipeline registers with per-stage valid; a stalled stage holds its data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
      end else begin
         if (in_ready) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) s1_q <= s1_d;
         end
         if (adv) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) s2_q <= s2_d;
         end
      end
   end

   assign out_valid  = vld_pipe[2];
   assign out_exact  = s2_q.exact;
   assign out_approx = s2_q.approx;
   assign out_err    = s2_q.err;
   assign out_viol   = s2_q.viol;

   // Saturating statistics over delivered results; clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
         viol_cnt   <= '0;
         max_err    <= '0;
      end else if (clear_stats) begin
         sample_cnt <= '0;
         viol_cnt   <= '0;
         max_err    <= '0;
      end else if (out_fire) begin
         if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
         if (s2_q.viol && (viol_cnt != '1)) viol_cnt <= viol_cnt + 1'b1;
         if (s2_q.err > max_err) max_err <= s2_q.err;
      end
   end

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// Randomized and directed bench for abs_diff_approx_pipe with a queue-based
// reference model checked on every falling edge.
module tb_abs_diff_approx_pipe;

   localparam int WIDTH = 4;
   localparam int DMAX  = 3;
   localparam int ET    = 2;
   localparam int CNT_W = 5;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0, in_b = '0;
   logic [2:0]       in_drop = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_exact, out_approx, out_err;
   logic             out_viol;
   logic             clear_stats = 1'b0;
   logic [CNT_W-1:0] sample_cnt, viol_cnt;
   logic [WIDTH-1:0] max_err;

   int checks = 0;
   int failures = 0;

   abs_diff_approx_pipe #(.WIDTH(WIDTH), .DROP_MAX(DMAX), .ET(ET), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_drop(in_drop), .out_valid(out_valid),
      .out_ready(out_ready), .out_exact(out_exact), .out_approx(out_approx),
      .out_err(out_err), .out_viol(out_viol), .clear_stats(clear_stats),
      .sample_cnt(sample_cnt), .viol_cnt(viol_cnt), .max_err(max_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: pairs in flight, with results computed by plain arithmetic.
   typedef struct {
      int exact;
      int approx;
      int err;
      int viol;
      int cyc;
   } ent_t;

   ent_t q[$];
   int   cyc = 0;
   int   m_samp = 0, m_viol = 0, m_max = 0;
   bit   hold = 0;
   int   h_exact, h_approx, h_err, h_viol;

   function automatic ent_t model(input int a, input int b, input int d, input int c);
      ent_t e;
      int p;
      e.exact  = (a > b) ? a - b : b - a;
      p        = 1 << ((d > DMAX) ? DMAX : d);
      e.err    = e.exact % p;
      e.approx = e.exact - e.err;
      e.viol   = (e.err > ET) ? 1 : 0;
      e.cyc    = c;
      return e;
   endfunction

   // Compare process: outputs, handshakes and statistics against the model.
   always @(negedge clk) begin
      bit   exp_v, exp_rdy;
      ent_t e;
      cyc++;
      if (!rst_n) begin
         q.delete();
         m_samp = 0; m_viol = 0; m_max = 0; hold = 0;
         chk("rst in_ready", in_ready, 0);
         chk("rst out_valid", out_valid, 0);
         chk("rst out_exact", out_exact, 0);
         chk("rst out_approx", out_approx, 0);
         chk("rst out_err", out_err, 0);
         chk("rst out_viol", out_viol, 0);
         chk("rst sample_cnt", sample_cnt, 0);
         chk("rst viol_cnt", viol_cnt, 0);
         chk("rst max_err", max_err, 0);
      end else begin
         chk("sample_cnt", sample_cnt, m_samp);
         chk("viol_cnt", viol_cnt, m_viol);
         chk("max_err", max_err, m_max);
         exp_rdy = (q.size() < 2) || out_ready;
         exp_v   = (q.size() > 0) && (cyc >= q[0].cyc + 2);
         chk("in_ready", in_ready, exp_rdy);
         chk("out_valid", out_valid, exp_v);
         if (hold) begin
            chk("stall exact", out_exact, h_exact);
            chk("stall approx", out_approx, h_approx);
            chk("stall err", out_err, h_err);
            chk("stall viol", out_viol, h_viol);
         end
         if (exp_v && out_ready) begin
            e = q.pop_front();
            chk("out_exact", out_exact, e.exact);
            chk("out_approx", out_approx, e.approx);
            chk("out_err", out_err, e.err);
            chk("out_viol", out_viol, e.viol);
            if (!clear_stats) begin
               if (m_samp < CMAX) m_samp++;
               if (e.viol != 0 && m_viol < CMAX) m_viol++;
               if (e.err > m_max) m_max = e.err;
            end
         end
         if (clear_stats) begin
            m_samp = 0; m_viol = 0; m_max = 0;
         end
         if (in_valid && exp_rdy)
            q.push_back(model(int'(in_a), int'(in_b), int'(in_drop), cyc));
         hold = exp_v && !out_ready;
         h_exact = out_exact; h_approx = out_approx; h_err = out_err; h_viol = out_viol;
      end
   end

   task automatic drive(input int a, input int b, input int d);
      in_valid = 1'b1;
      in_a     = WIDTH'(a);
      in_b     = WIDTH'(b);
      in_drop  = 3'(d);
   endtask

   // One pair through an idle pipe with literal expectations two cycles later.
   task automatic send_chk(input int a, input int b, input int d,
                           input int ex, input int ap, input int er, input int vi);
      @(posedge clk); #1 drive(a, b, d);
      @(negedge clk);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("lat N+1 out_valid", out_valid, 0);
      @(negedge clk);
      chk("lat N+2 out_valid", out_valid, 1);
      chk("lit exact", out_exact, ex);
      chk("lit approx", out_approx, ap);
      chk("lit err", out_err, er);
      chk("lit viol", out_viol, vi);
   endtask

   task automatic stats_chk(input int s, input int v, input int m);
      @(negedge clk);
      chk("lit sample_cnt", sample_cnt, s);
      chk("lit viol_cnt", viol_cnt, v);
      chk("lit max_err", max_err, m);
   endtask

   initial begin
      // Reset, then idle pipe.
      @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("idle in_ready", in_ready, 1);
      chk("idle out_valid", out_valid, 0);
      @(negedge clk);
      chk("idle out_valid 2", out_valid, 0);

      // Literal results and statistics.
      send_chk(9, 3, 0, 6, 6, 0, 0);    stats_chk(1, 0, 0);
      send_chk(2, 13, 2, 11, 8, 3, 1);  stats_chk(2, 1, 3);
      send_chk(15, 0, 7, 15, 8, 7, 1);  stats_chk(3, 2, 7);

      // Clear, then backpressure with three offered pairs.
      @(posedge clk); #1 clear_stats = 1'b1;
      @(posedge clk); #1 clear_stats = 1'b0; out_ready = 1'b0; drive(1, 2, 0);
      @(negedge clk); chk("bp rdy1", in_ready, 1);
      @(posedge clk); #1 drive(5, 5, 1);
      @(negedge clk); chk("bp rdy2", in_ready, 1);
      @(posedge clk); #1 drive(12, 4, 3);
      @(negedge clk); chk("bp full rdy", in_ready, 0); chk("bp head", out_exact, 1);
      @(posedge clk);
      @(negedge clk); chk("bp full rdy 2", in_ready, 0); chk("bp head stable", out_exact, 1);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk); chk("bp res1", out_exact, 1); chk("bp rdy release", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk); chk("bp res2", out_exact, 0);
      @(negedge clk); chk("bp res3", out_exact, 8); chk("bp res3 approx", out_approx, 8);
      stats_chk(3, 0, 0);

      // Clear coincident with an output handshake.
      @(posedge clk); #1 drive(2, 13, 2);
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1 clear_stats = 1'b1;
      @(negedge clk); chk("clr out_valid", out_valid, 1);
      @(posedge clk); #1 clear_stats = 1'b0;
      @(negedge clk);
      chk("clr sample_cnt", sample_cnt, 0);
      chk("clr viol_cnt", viol_cnt, 0);
      chk("clr max_err", max_err, 0);

      // Reset with both stages full: nothing survives.
      @(posedge clk); #1 out_ready = 1'b0; drive(7, 1, 1);
      @(posedge clk); #1 drive(3, 9, 0);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk); chk("full in_ready", in_ready, 0); chk("full out_valid", out_valid, 1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1 chk("async out_valid", out_valid, 0); chk("async out_exact", out_exact, 0);
      @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); chk("post rst out_valid", out_valid, 0);
      end

      // Randomized traffic; statistics reach saturation.
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         in_valid    = ($urandom_range(0, 9) < 7);
         in_a        = WIDTH'($urandom);
         in_b        = WIDTH'($urandom);
         in_drop     = 3'($urandom);
         out_ready   = ($urandom_range(0, 9) < 6);
         clear_stats = (i < 100) && ($urandom_range(0, 49) == 0);
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;
      repeat (5) @(negedge clk);
      chk("sat sample_cnt", sample_cnt, CMAX);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
